// File: rtl/ahb_lite_slave_mem_pkg.sv
// ahb_lite_slave_mem_pkg
// Shared bus types and constants for the AHB-Lite memory slave, plus the
// helpers that turn a transfer size and low address bits into byte lanes.
package ahb_lite_slave_mem_pkg;

  localparam int ADDRWIDTH         = 32;
  localparam int DATAWIDTH         = 32;
  localparam int TRANS_WIDTH       = 2;
  localparam int DATATRANFER_SIZE  = 3;
  localparam int BURST_TYPE        = 3;
  localparam int SLAVE_ADDRWIDTH   = 8;
  localparam int SLAVE_DATAWIDTH   = 8;

  // HTRANS encodings; prefixed so they do not collide with the slave states.
  typedef enum logic [TRANS_WIDTH-1:0] {
    TRANS_IDLE   = 2'b00,
    TRANS_BUSY   = 2'b01,
    TRANS_NONSEQ = 2'b10,
    TRANS_SEQ    = 2'b11
  } Trans_t;

  typedef enum logic [BURST_TYPE-1:0] {
    SINGLE = 3'd0,
    INCR   = 3'd1,
    WRAP4  = 3'd2,
    INCR4  = 3'd3,
    WRAP8  = 3'd4,
    INCR8  = 3'd5,
    WRAP16 = 3'd6,
    INCR16 = 3'd7
  } BType_t;

  typedef enum logic {
    OKAY  = 1'b0,
    ERROR = 1'b1
  } Response_t;

  typedef enum logic [DATATRANFER_SIZE-1:0] {
    BYTE     = 3'd0,
    HALFWORD = 3'd1,
    WORD     = 3'd2
  } Size_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ERR1,
    ERR2
  } SlaveState_t;

  // Little-endian byte lanes touched by a legal transfer. Halfwords are
  // already known to be aligned here, so only addr_lo[1] picks the half.
  function automatic logic [3:0] lane_mask(input logic [1:0] addr_lo,
                                           input Size_t size);
    logic [3:0] mask;
    case (size)
      BYTE:     mask = 4'b0001 << addr_lo;
      HALFWORD: mask = addr_lo[1] ? 4'b1100 : 4'b0011;
      default:  mask = 4'b1111;
    endcase
    return mask;
  endfunction

  // Widen a 4-bit lane mask to a 32-bit data mask.
  function automatic logic [DATAWIDTH-1:0] lane_bits(input logic [3:0] lanes);
    logic [DATAWIDTH-1:0] bits;
    for (int i = 0; i < 4; i++) begin
      bits[8*i +: 8] = {8{lanes[i]}};
    end
    return bits;
  endfunction

endpackage

// File: rtl/ahb_lite_slave_mem_mem.sv
// ahb_byte_mem
// Word-organised storage built from four independent byte lanes so that
// byte and halfword writes only disturb the lanes they own.
// Ports:
//   clk    - write clock
//   we     - per-lane write enable (lane i = bits [8i+7:8i])
//   waddr  - word index for writes
//   wdata  - 32-bit write data, already lane-aligned
//   raddr  - word index for reads
//   rdata  - 32-bit asynchronous read data
module ahb_byte_mem
  import ahb_lite_slave_mem_pkg::*;
#(
  parameter int MEM_ADDRWIDTH = SLAVE_ADDRWIDTH
) (
  input  logic                     clk,
  input  logic [3:0]               we,
  input  logic [MEM_ADDRWIDTH-3:0] waddr,
  input  logic [DATAWIDTH-1:0]     wdata,
  input  logic [MEM_ADDRWIDTH-3:0] raddr,
  output logic [DATAWIDTH-1:0]     rdata
);

  localparam int DEPTH = 2 ** (MEM_ADDRWIDTH - 2);

  // Contents are deliberately left unreset; only the bus logic has reset.
  for (genvar lane = 0; lane < 4; lane++) begin : g_lane
    logic [SLAVE_DATAWIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
      if (we[lane]) begin
        mem[waddr] <= wdata[8*lane +: 8];
      end
    end

    assign rdata[8*lane +: 8] = mem[raddr];
  end

endmodule

// File: rtl/ahb_lite_slave_mem.sv
// ahb_lite_slave_mem
// AHB-Lite responder in front of a 2**MEM_ADDRWIDTH byte memory. Registers
// the address phase, optionally stretches the data phase by WAIT_STATES
// cycles, and answers illegal transfers with the two-cycle ERROR response.
// Ports:
//   HCLK, HRESETn          - bus clock, asynchronous active-low reset
//   HSEL, HADDR, HTRANS,
//   HWRITE, HSIZE, HBURST  - address-phase controls (HBURST is ignored)
//   HREADY                 - bus ready, qualifies the address phase
//   HWDATA                 - write data during the data phase
//   HRDATA                 - read data, zero outside read data phases
//   HREADYOUT, HRESP       - slave completion and response
module ahb_lite_slave_mem
  import ahb_lite_slave_mem_pkg::*;
#(
  parameter int WAIT_STATES   = 0,
  parameter int MEM_ADDRWIDTH = SLAVE_ADDRWIDTH
) (
  input  logic                        HCLK,
  input  logic                        HRESETn,
  input  logic                        HSEL,
  input  logic [ADDRWIDTH-1:0]        HADDR,
  input  logic [TRANS_WIDTH-1:0]      HTRANS,
  input  logic                        HWRITE,
  input  logic [DATATRANFER_SIZE-1:0] HSIZE,
  input  logic [BURST_TYPE-1:0]       HBURST,
  input  logic                        HREADY,
  input  logic [DATAWIDTH-1:0]        HWDATA,
  output logic [DATAWIDTH-1:0]        HRDATA,
  output logic                        HREADYOUT,
  output logic                        HRESP
);

  localparam bit         HAS_WAIT  = (WAIT_STATES > 0);
  localparam logic [3:0] WAIT_LOAD = HAS_WAIT ? 4'(WAIT_STATES - 1) : 4'd0;

  SlaveState_t state, state_next;
  logic [3:0]  wait_cnt, wait_cnt_next;

  logic                     dp_valid;
  logic                     dp_write;
  logic [MEM_ADDRWIDTH-1:0] dp_addr;
  Size_t                    dp_size;

  logic accept;
  logic addr_err, size_err, align_err, req_err;

  logic [3:0]           lanes;
  logic [3:0]           mem_we;
  logic [DATAWIDTH-1:0] mem_rdata;

  logic unused_burst;
  assign unused_burst = ^HBURST;

  assign accept = HSEL && HREADY &&
                  ((HTRANS == TRANS_NONSEQ) || (HTRANS == TRANS_SEQ));

  assign addr_err  = (HADDR >> MEM_ADDRWIDTH) != '0;
  assign size_err  = HSIZE > 3'd2;
  assign align_err = ((HSIZE == 3'd1) && HADDR[0]) ||
                     ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00));
  assign req_err   = addr_err || size_err || align_err;

  // Address-phase capture. dp_valid marks a legal transfer whose data phase
  // is in progress; an errored transfer leaves it low so it can never write.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_addr  <= '0;
      dp_size  <= BYTE;
    end else if (HREADY) begin
      dp_valid <= accept && !req_err;
      if (accept) begin
        dp_write <= HWRITE;
        dp_addr  <= HADDR[MEM_ADDRWIDTH-1:0];
        dp_size  <= size_err ? BYTE : Size_t'(HSIZE);
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state    <= IDLE;
      wait_cnt <= 4'd0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
    end
  end

  // ERR2 already drives HREADYOUT high, so it accepts a new address phase
  // exactly like IDLE does.
  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    case (state)
      IDLE, ERR2: begin
        state_next = IDLE;
        if (accept) begin
          if (req_err) begin
            state_next = ERR1;
          end else if (HAS_WAIT) begin
            state_next    = WAIT;
            wait_cnt_next = WAIT_LOAD;
          end
        end
      end
      WAIT: begin
        if (wait_cnt == 4'd0) begin
          state_next = IDLE;
        end else begin
          wait_cnt_next = wait_cnt - 4'd1;
        end
      end
      ERR1:    state_next = ERR2;
      default: state_next = IDLE;
    endcase
  end

  assign HREADYOUT = (state == IDLE) || (state == ERR2);
  assign HRESP     = ((state == ERR1) || (state == ERR2)) ? ERROR : OKAY;

  assign lanes = lane_mask(dp_addr[1:0], dp_size);

  // A legal write's data phase ends in the cycle the FSM sits in IDLE.
  assign mem_we = (dp_valid && dp_write && (state == IDLE)) ? lanes : 4'b0000;

  // Read data is combinational from the memory, so a read directly after a
  // write to the same word sees the freshly committed bytes.
  assign HRDATA = (dp_valid && !dp_write) ? (mem_rdata & lane_bits(lanes)) : '0;

  ahb_byte_mem #(
    .MEM_ADDRWIDTH(MEM_ADDRWIDTH)
  ) u_mem (
    .clk  (HCLK),
    .we   (mem_we),
    .waddr(dp_addr[MEM_ADDRWIDTH-1:2]),
    .wdata(HWDATA),
    .raddr(dp_addr[MEM_ADDRWIDTH-1:2]),
    .rdata(mem_rdata)
  );

endmodule
